inst_fetch_ctrl: RTL

//  Writer side of the decode instruction FIFO. Owns the fetch PC and issues 64-bit
//  (two-instruction) requests on the SRAM-like instruction bus. Pushes returned

---
 rtl/cdim_if_pkg.sv | 14 +
 rtl/inst_fetch_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cdim_if_pkg.sv
// rtl/cdim_if_pkg.sv - shared types and constants for the IF-stage fetch controller
package cdim_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - fetch PC owner, 64-bit instruction bus requester, decode FIFO writer
// Optional macro FETCH_ADEL_EN adds misaligned-PC fetch exception reporting.
module inst_fetch_ctrl
  import cdim_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        fifo_full,
  output logic        fifo_rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
`ifdef FETCH_ADEL_EN
  output logic        fetch_adel,
  output logic [31:0] fetch_badvaddr,
`endif
  output logic        write_en1,
  output logic        write_en2,
  output logic [31:0] write_address1,
  output logic [31:0] write_address2,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  inflight_pc;
  logic         discard;
  logic         adel_lock;
  logic         pc_misaligned;
  logic [31:0]  redirect_target;
  logic [31:0]  pc_step;
  logic         accept;
  logic         push;
  logic         adel_push;

`ifdef FETCH_ADEL_EN
  assign pc_misaligned   = (pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
`else
  assign pc_misaligned   = 1'b0;
  assign redirect_target = redirect_pc & PC_ALIGN_MASK;
`endif

  // An odd-word PC fetches only the upper half of the pair, so it advances by one word.
  assign pc_step   = pc[2] ? 32'd4 : 32'd8;
  assign inst_req  = !rst && (state == REQ) && !pc_misaligned;
  assign inst_addr = {pc[31:3], 3'b000};
  assign fifo_rst  = !rst && redirect;
  assign accept    = inst_req && inst_addr_ok;
  assign push      = !rst && (state == WAIT) && inst_data_ok && !discard && !redirect;
  assign adel_push = !rst && (state == REQ) && pc_misaligned && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      discard     <= 1'b0;
      adel_lock   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_full && !adel_lock) state <= REQ;
        end
        REQ: begin
          if (adel_push) begin
            state     <= IDLE;
            adel_lock <= 1'b1;
          end else if (accept) begin
            inflight_pc <= pc;
            state       <= WAIT;
            if (redirect) discard <= 1'b1;
            else          pc      <= pc + pc_step;
          end
        end
        WAIT: begin
          // A response coinciding with a redirect is simply dropped; no stale one remains.
          if (inst_data_ok) begin
            discard <= 1'b0;
            state   <= fifo_full ? IDLE : REQ;
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
      if (redirect) begin
        pc        <= redirect_target;
        adel_lock <= 1'b0;
      end
    end
  end

  always_comb begin
    write_en1      = 1'b0;
    write_en2      = 1'b0;
    write_address1 = inflight_pc;
    write_address2 = inflight_pc + 32'd4;
    write_data1    = inflight_pc[2] ? inst_rdata[63:32] : inst_rdata[31:0];
    write_data2    = inst_rdata[63:32];
`ifdef FETCH_ADEL_EN
    fetch_adel     = 1'b0;
    fetch_badvaddr = pc;
`endif
    if (push) begin
      write_en1 = 1'b1;
      write_en2 = !inflight_pc[2];
    end else if (adel_push) begin
      write_en1      = 1'b1;
      write_address1 = pc;
      write_data1    = INST_NOP;
`ifdef FETCH_ADEL_EN
      fetch_adel     = 1'b1;
`endif
    end
  end

endmodule
